// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronized, debounced, edge-latched interrupt sources
// arbitrated by fixed priority into one CP0 request with take/eret.
module irq_ctrl #(
  parameter int N_SRC      = 4,
  parameter int DEB_CYCLES = 16,
  parameter int ID_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic [N_SRC-1:0] mask,
  input  logic             take,
  input  logic             eret,
  output logic             ir_out,
  output logic [ID_W-1:0]  cause_id,
  output logic [N_SRC-1:0] pending,
  output logic             busy
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [N_SRC-1:0] meta_q, meta_d;
  logic [N_SRC-1:0] sync_q, sync_d;
  logic [N_SRC-1:0] deb_q, deb_d;
  logic [N_SRC-1:0] deb_prev_q, deb_prev_d;
  logic [CW-1:0]    cnt_q [N_SRC];
  logic [CW-1:0]    cnt_d [N_SRC];
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  cid_q, cid_d;
  logic             ir_q, ir_d;
  logic             busy_q, busy_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  win;

  // Two-flop synchronizer per raw source.
  always_comb begin
    meta_d = src_in;
    sync_d = meta_q;
  end

  // Debounce: level changes only after DEB_CYCLES stable differing cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N_SRC; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Rising-edge detect and fixed-priority pick (lowest index wins).
  always_comb begin
    deb_prev_d = deb_q;
    rise       = deb_q & ~deb_prev_q;
    cand       = pend_q & mask;
    win        = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win = ID_W'(i);
    end
  end

  // Request FSM; a new edge on the taken source beats the take clear.
  always_comb begin
    state_d = state_q;
    cid_d   = cid_q;
    clr     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|cand) begin
          state_d = S_REQ;
          cid_d   = win;
        end
      end
      S_REQ: begin
        if (take) begin
          state_d = S_SVC;
          clr     = N_SRC'(1) << cid_q;
        end
      end
      S_SVC: begin
        if (eret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = (pend_q & ~clr) | rise;
    ir_d   = (state_d == S_REQ);
    busy_d = (state_d == S_SVC);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
      pend_q     <= '0;
      state_q    <= S_IDLE;
      cid_q      <= '0;
      ir_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      cid_q      <= cid_d;
      ir_q       <= ir_d;
      busy_q     <= busy_d;
    end
  end

  assign ir_out   = ir_q;
  assign cause_id = cid_q;
  assign pending  = pend_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: cycle-tagged expectation scoreboard plus request-id
// scoreboard checked by an independent monitor on the falling edge.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_in;
  logic [3:0] mask;
  logic       take;
  logic       eret;
  logic       ir_out;
  logic [1:0] cause_id;
  logic [3:0] pending;
  logic       busy;

  irq_ctrl #(.N_SRC(4), .DEB_CYCLES(4), .ID_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_in   (src_in),
    .mask     (mask),
    .take     (take),
    .eret     (eret),
    .ir_out   (ir_out),
    .cause_id (cause_id),
    .pending  (pending),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       ir;
    logic       bz;
    logic [3:0] pend;
    int         cid;
  } exp_t;

  exp_t exq[$];
  int   reqq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic ir_prev = 1'b0;
  exp_t e_m;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, int a, int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", n, a, x, cyc);
    end
  endfunction

  // Expected outputs after edge 'at' (cid < 0: cause_id not checked).
  function automatic void ex(int at, logic ir, logic bz,
                             logic [3:0] p, int cid);
    exp_t e;
    int   i;
    e = '{at, ir, bz, p, cid};
    i = 0;
    while (i < exq.size() && exq[i].cyc <= at) i++;
    exq.insert(i, e);
  endfunction

  // Monitor: compares snapshots and every new request's id.
  always @(negedge clk) begin
    while (exq.size() > 0 && exq[0].cyc <= cyc) begin
      e_m = exq.pop_front();
      if (e_m.cyc < cyc) begin
        chk("exp_missed", cyc, e_m.cyc);
      end else begin
        chk("ir_out", int'(ir_out), int'(e_m.ir));
        chk("busy", int'(busy), int'(e_m.bz));
        chk("pending", int'(pending), int'(e_m.pend));
        if (e_m.cid >= 0) chk("cause_id", int'(cause_id), e_m.cid);
      end
    end
    if (ir_out && !ir_prev) begin
      if (reqq.size() == 0) chk("unexpected_req", int'(cause_id), -1);
      else chk("req_id", int'(cause_id), reqq.pop_front());
    end
    ir_prev <= ir_out;
  end

  task automatic goto(int c);
    while (cyc < c) @(negedge clk);
  endtask

  int b;

  initial begin
    rst = 1'b1; src_in = '0; mask = '0; take = 1'b0; eret = 1'b0;
    @(negedge clk);

    // Reset held with all sources high.
    b = cyc;
    src_in = 4'hF;
    for (int k = 1; k <= 3; k++) ex(b + k, 0, 0, 4'h0, 0);
    goto(b + 3);
    rst = 1'b0;
    b = cyc;
    ex(b + 6, 0, 0, 4'h0, 0);
    ex(b + 7, 0, 0, 4'hF, 0);
    goto(b + 7);
    rst = 1'b1; src_in = '0;
    b = cyc;
    ex(b + 1, 0, 0, 4'h0, 0);
    goto(b + 1);
    rst = 1'b0; mask = 4'hF;

    // Debounce with bouncing source 1, then take, eret, spurious take.
    b = cyc;
    for (int k = 1; k <= 10; k++) ex(b + k, 0, 0, 4'h0, -1);
    ex(b + 11, 0, 0, 4'h2, -1);
    ex(b + 12, 1, 0, 4'h2, 1);
    reqq.push_back(1);
    ex(b + 13, 0, 1, 4'h0, 1);
    ex(b + 14, 0, 1, 4'h0, 1);
    ex(b + 15, 0, 0, 4'h0, 1);
    ex(b + 16, 0, 0, 4'h0, 1);
    src_in = 4'b0010;
    goto(b + 1); src_in = 4'b0000;
    goto(b + 2); src_in = 4'b0010;
    goto(b + 3); src_in = 4'b0000;
    goto(b + 4); src_in = 4'b0010;
    goto(b + 12); take = 1'b1;
    goto(b + 13); take = 1'b0;
    goto(b + 14); eret = 1'b1;
    goto(b + 15); eret = 1'b0; take = 1'b1;
    goto(b + 16); take = 1'b0;

    // Priority under mask, spurious eret in REQ, unmask in SERVICE.
    goto(b + 17);
    b = cyc;
    mask = 4'b1011; src_in = 4'b1110;
    ex(b + 6, 0, 0, 4'h0, -1);
    ex(b + 7, 0, 0, 4'hC, -1);
    ex(b + 8, 1, 0, 4'hC, 3);
    reqq.push_back(3);
    ex(b + 9, 1, 0, 4'hC, 3);
    ex(b + 10, 0, 1, 4'h4, 3);
    ex(b + 11, 0, 1, 4'h4, 3);
    ex(b + 12, 0, 0, 4'h4, 3);
    ex(b + 13, 1, 0, 4'h4, 2);
    reqq.push_back(2);
    ex(b + 14, 0, 1, 4'h0, 2);
    ex(b + 15, 0, 0, 4'h0, 2);
    ex(b + 16, 0, 0, 4'h0, 2);
    goto(b + 8); eret = 1'b1;
    goto(b + 9); eret = 1'b0; take = 1'b1;
    goto(b + 10); take = 1'b0; mask = 4'hF;
    goto(b + 11); eret = 1'b1;
    goto(b + 12); eret = 1'b0;
    goto(b + 13); take = 1'b1;
    goto(b + 14); take = 1'b0; eret = 1'b1;
    goto(b + 15); eret = 1'b0;

    // New edge on source 0 coincides with its take.
    goto(b + 16);
    b = cyc;
    src_in = 4'b1111;
    ex(b + 7, 0, 0, 4'h1, -1);
    ex(b + 8, 1, 0, 4'h1, 0);
    reqq.push_back(0);
    ex(b + 18, 1, 0, 4'h1, 0);
    ex(b + 19, 0, 1, 4'h1, 0);
    ex(b + 20, 0, 0, 4'h1, 0);
    ex(b + 21, 1, 0, 4'h1, 0);
    reqq.push_back(0);
    goto(b + 6); src_in = 4'b1110;
    goto(b + 12); src_in = 4'b1111;
    goto(b + 18); take = 1'b1;
    goto(b + 19); take = 1'b0; eret = 1'b1;
    goto(b + 20); eret = 1'b0;

    // Reset during SERVICE with pending = 0100.
    goto(b + 21);
    take = 1'b1; src_in = 4'b1011;
    ex(b + 22, 0, 1, 4'h0, 0);
    ex(b + 33, 0, 1, 4'h0, 0);
    ex(b + 34, 0, 1, 4'h4, 0);
    ex(b + 35, 0, 0, 4'h0, 0);
    for (int k = 36; k <= 46; k++) ex(b + k, 0, 0, 4'h0, 0);
    ex(b + 47, 0, 0, 4'h8, 0);
    ex(b + 48, 1, 0, 4'h8, 3);
    reqq.push_back(3);
    ex(b + 49, 0, 1, 4'h0, 3);
    goto(b + 22); take = 1'b0;
    goto(b + 27); src_in = 4'b1111;
    goto(b + 34); rst = 1'b1; src_in = 4'b0000;
    goto(b + 35); rst = 1'b0;
    goto(b + 40); src_in = 4'b1000;
    goto(b + 48); take = 1'b1;
    goto(b + 49); take = 1'b0;
    goto(b + 52);

    chk("exp_left", exq.size(), 0);
    chk("req_left", reqq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
